// File: rtl/snitch_ro_cache_ctrl.sv
// Configuration and sequencing controller for the read-only constant cache.
// Behaviour-changing writes run drain -> flush -> apply before the new settings take effect.
module snitch_ro_cache_ctrl #(
    parameter int unsigned NrAddrRules = 1,
    parameter int unsigned AddrWidth   = 32,
    parameter int unsigned MaxTrans    = 4
) (
    input  logic                                  clk_i,
    input  logic                                  rst_ni,
    input  logic                                  cfg_req_valid_i,
    output logic                                  cfg_req_ready_o,
    input  logic                                  cfg_req_write_i,
    input  logic [7:0]                            cfg_req_addr_i,
    input  logic [AddrWidth-1:0]                  cfg_req_wdata_i,
    output logic                                  cfg_rsp_valid_o,
    output logic [AddrWidth-1:0]                  cfg_rsp_rdata_o,
    output logic                                  cfg_rsp_error_o,
    input  logic                                  ar_cache_hs_i,
    input  logic                                  r_cache_last_hs_i,
    output logic                                  enable_o,
    output logic                                  flush_valid_o,
    input  logic                                  flush_ready_i,
    output logic [NrAddrRules-1:0][AddrWidth-1:0] start_addr_o,
    output logic [NrAddrRules-1:0][AddrWidth-1:0] end_addr_o
);

    localparam int unsigned CntWidth = $clog2(MaxTrans + 1);

    localparam logic [7:0] RegEnable    = 8'h00;
    localparam logic [7:0] RegFlush     = 8'h04;
    localparam logic [7:0] RegStatus    = 8'h08;
    localparam logic [7:0] RegCommit    = 8'h0C;
    localparam logic [5:0] RuleWordBase = 6'h04;
    localparam logic [5:0] NrRules      = 6'(NrAddrRules);

    typedef enum logic [1:0] {StIdle, StDrain, StFlush, StApply} state_e;

    state_e                                state_q, state_d;
    logic                                  enable_q, enable_d;
    logic                                  shadow_en_q, shadow_en_d;
    logic [CntWidth-1:0]                   cnt_q, cnt_d;
    logic [NrAddrRules-1:0][AddrWidth-1:0] shadow_start_q, shadow_end_q;
    logic [NrAddrRules-1:0][AddrWidth-1:0] active_start_q, active_end_q;
    logic                                  rsp_valid_q;
    logic [AddrWidth-1:0]                  rsp_rdata_q, rsp_rdata_d;
    logic                                  rsp_error_q, rsp_error_d;

    logic       is_enable, is_flush, is_status, is_commit, is_rule, rule_is_end;
    logic [5:0] rule_word;
    logic [4:0] rule_idx;
    logic       busy, accept, wr, trig_seq, en_clear;

    // Address decode: rules occupy consecutive START/END word pairs from 0x10.
    always_comb begin
        is_enable   = (cfg_req_addr_i == RegEnable);
        is_flush    = (cfg_req_addr_i == RegFlush);
        is_status   = (cfg_req_addr_i == RegStatus);
        is_commit   = (cfg_req_addr_i == RegCommit);
        rule_word   = cfg_req_addr_i[7:2] - RuleWordBase;
        rule_idx    = rule_word[5:1];
        rule_is_end = rule_word[0];
        is_rule     = (cfg_req_addr_i[1:0] == 2'b00) &&
                      (cfg_req_addr_i[7:2] >= RuleWordBase) &&
                      ({1'b0, rule_idx} < NrRules);
    end

    always_comb begin
        busy            = (state_q != StIdle);
        // Sequence-triggering writes stall while a sequence is running.
        cfg_req_ready_o = rst_ni &
                          ~(busy & cfg_req_write_i & (is_enable | is_flush | is_commit));
        accept          = cfg_req_valid_i & cfg_req_ready_o;
        wr              = accept & cfg_req_write_i;
        trig_seq        = wr & ((is_enable & cfg_req_wdata_i[0]) | is_flush | is_commit);
        en_clear        = wr & is_enable & ~cfg_req_wdata_i[0];
    end

    // Response data is captured at accept time and presented one cycle later.
    always_comb begin
        rsp_rdata_d = '0;
        rsp_error_d = 1'b0;
        if (is_enable) begin
            rsp_rdata_d[0] = shadow_en_q;
        end else if (is_flush || is_commit) begin
            rsp_rdata_d = '0;
        end else if (is_status) begin
            if (cfg_req_write_i) begin
                rsp_error_d = 1'b1;
            end else begin
                rsp_rdata_d[0]             = busy;
                rsp_rdata_d[1]             = enable_q;
                rsp_rdata_d[16 +: CntWidth] = cnt_q;
            end
        end else if (is_rule) begin
            for (int unsigned i = 0; i < NrAddrRules; i++) begin
                if (rule_idx == 5'(i)) begin
                    rsp_rdata_d = rule_is_end ? shadow_end_q[i] : shadow_start_q[i];
                end
            end
        end else begin
            rsp_error_d = 1'b1;
        end
        if (cfg_req_write_i || rsp_error_d) begin
            rsp_rdata_d = '0;
        end
    end

    always_comb begin
        cnt_d = cnt_q;
        if (ar_cache_hs_i && !r_cache_last_hs_i) begin
            cnt_d = cnt_q + CntWidth'(1);
        end else if (!ar_cache_hs_i && r_cache_last_hs_i) begin
            cnt_d = cnt_q - CntWidth'(1);
        end
    end

    always_comb begin
        state_d     = state_q;
        enable_d    = enable_q;
        shadow_en_d = shadow_en_q;
        if (wr && is_enable) begin
            shadow_en_d = cfg_req_wdata_i[0];
        end
        unique case (state_q)
            StIdle: begin
                if (trig_seq) begin
                    state_d  = StDrain;
                    enable_d = 1'b0;
                end else if (en_clear) begin
                    enable_d = 1'b0;
                end
            end
            StDrain: begin
                if (cnt_d == '0) begin
                    state_d = StFlush;
                end
            end
            StFlush: begin
                if (flush_ready_i) begin
                    state_d = StApply;
                end
            end
            StApply: begin
                enable_d = shadow_en_q;
                state_d  = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q        <= StIdle;
            enable_q       <= 1'b0;
            shadow_en_q    <= 1'b0;
            cnt_q          <= '0;
            shadow_start_q <= '0;
            shadow_end_q   <= '0;
            active_start_q <= '0;
            active_end_q   <= '0;
            rsp_valid_q    <= 1'b0;
            rsp_rdata_q    <= '0;
            rsp_error_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            enable_q    <= enable_d;
            shadow_en_q <= shadow_en_d;
            cnt_q       <= cnt_d;
            rsp_valid_q <= accept;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_error_q <= rsp_error_d;
            for (int unsigned i = 0; i < NrAddrRules; i++) begin
                if (wr && is_rule && (rule_idx == 5'(i))) begin
                    if (rule_is_end) begin
                        shadow_end_q[i] <= cfg_req_wdata_i;
                    end else begin
                        shadow_start_q[i] <= cfg_req_wdata_i;
                    end
                end
            end
            if (state_q == StApply) begin
                active_start_q <= shadow_start_q;
                active_end_q   <= shadow_end_q;
            end
        end
    end

    assign cfg_rsp_valid_o = rsp_valid_q;
    assign cfg_rsp_rdata_o = rsp_rdata_q;
    assign cfg_rsp_error_o = rsp_error_q;
    assign enable_o        = enable_q;
    assign flush_valid_o   = (state_q == StFlush);
    assign start_addr_o    = active_start_q;
    assign end_addr_o      = active_end_q;

endmodule
